// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache external-memory protocol: responder states,
// default latencies and byte-address to word-index helpers.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RBUSY = 2'd1,
        WBUSY = 2'd2,
        RDONE = 2'd3
    } state_t;

    localparam int DEF_READ_LATENCY  = 4;
    localparam int DEF_WRITE_LATENCY = 4;

    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return addr[31:2];
    endfunction

    // True when no address bit above the word-index field is set.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
        return (addr >> (aw + 2)) == 32'h0;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between a cache (master) and the backing memory (slave).
interface mem_responder_if;
    // A request (mem_ren or mem_wen, with mem_addr/mem_wdata) is taken at a rising
    // edge where mem_ready is high; mem_ready then stays low until the access is
    // complete. A read answers with a one-cycle mem_valid pulse carrying mem_rdata;
    // a write completes silently. err is a sticky protocol-violation flag.
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        err;

    modport master (
        input  mem_ready, mem_rdata, mem_valid, err,
        output mem_addr, mem_ren, mem_wen, mem_wdata
    );

    modport slave (
        output mem_ready, mem_rdata, mem_valid, err,
        input  mem_addr, mem_ren, mem_wen, mem_wdata
    );
endinterface

// File: rtl/mem_word_array.sv
// Single-port word RAM with registered read, written so FPGA tools map it to block RAM.
module mem_word_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] words [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            words[addr] <= wdata;
        end
        rdata <= words[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Backing-memory responder: one outstanding request, fixed read/write latency,
// sticky error flag for misaligned, out-of-range or read+write requests.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_WORDS   = 1024,
    parameter int READ_LATENCY  = DEF_READ_LATENCY,
    parameter int WRITE_LATENCY = DEF_WRITE_LATENCY
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mem_responder_if.slave bus,
    output state_t         dbg_state
);

    localparam int AW      = $clog2(DEPTH_WORDS);
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d, req_idx, ram_addr;
    logic [31:0]   wdata_q, wdata_d, ram_q;
    logic          in_range_q, in_range_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          req_in_range, req_err, accept, ram_we;

    assign req_idx      = AW'(word_index(bus.mem_addr));
    assign req_in_range = addr_in_range(bus.mem_addr, AW);
    assign req_err      = (bus.mem_ren & bus.mem_wen) | (bus.mem_addr[1:0] != 2'b00) | ~req_in_range;
    assign accept       = (state_q == IDLE) && ready_q && (bus.mem_ren || bus.mem_wen);

    // While idle the RAM already looks up the presented address, so a one-cycle
    // read has its data on the RAM output right after the accepting edge.
    assign ram_addr = (state_q == IDLE) ? req_idx : idx_q;

    mem_word_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (i_clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(wdata_q),
        .rdata(ram_q)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            in_range_q <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            in_range_q <= in_range_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        in_range_d = in_range_q;
        ready_d    = ready_q;
        valid_d    = valid_q;
        err_d      = err_q;
        ram_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d      = req_idx;
                    wdata_d    = bus.mem_wdata;
                    in_range_d = req_in_range;
                    ready_d    = 1'b0;
                    err_d      = err_q | req_err;
                    if (bus.mem_wen) begin
                        cnt_d   = WR_LOAD;
                        state_d = WBUSY;
                    end else begin
                        cnt_d = RD_LOAD;
                        if (READ_LATENCY == 1) begin
                            valid_d = 1'b1;
                            state_d = RDONE;
                        end else begin
                            state_d = RBUSY;
                        end
                    end
                end
            end
            RBUSY: begin
                // valid is raised on the edge that takes the counter to zero
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_ONE) begin
                    valid_d = 1'b1;
                    state_d = RDONE;
                end
            end
            WBUSY: begin
                if (cnt_q == '0) begin
                    ram_we  = in_range_q;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RDONE: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_valid = valid_q;
    assign bus.err       = err_q;
    assign bus.mem_rdata = (valid_q && in_range_q) ? ram_q : 32'h0;
    assign dbg_state     = state_q;

endmodule
